// File: rtl/sub_share_arb.sv
// Round-robin arbiter that time-shares one sub datapath among NREQ requesters.
// Optional build macro SUB_ARB_SAT_EN: clamp the difference to 0 on borrow.

module sub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out
);
  assign out = in1 - in2;
endmodule

module sub_share_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_borrow
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr, gnt_id, grant;
  logic             grant_vld;
  logic [WIDTH-1:0] op_a, op_b, diff;
  logic             borrow;

  // Scan downward so the requester closest to ptr is written last and wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        grant     = IDW'((int'(ptr) + k) % NREQ);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  sub #(.WIDTH(WIDTH)) u_sub (
    .in1 (op_a),
    .in2 (op_b),
    .out (diff)
  );

  assign borrow = (op_a < op_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_vld) begin
          op_a   <= req_a[int'(grant)*WIDTH +: WIDTH];
          op_b   <= req_b[int'(grant)*WIDTH +: WIDTH];
          gnt_id <= grant;
          state  <= CALC;
        end
        CALC: begin
`ifdef SUB_ARB_SAT_EN
          rsp_data   <= borrow ? '0 : diff;
`else
          rsp_data   <= diff;
`endif
          rsp_borrow <= borrow;
          rsp_id     <= gnt_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr       <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_share_arb.sv
// Directed self-checking bench for sub_share_arb (WIDTH=32, NREQ=4).

module tb_sub_share_arb;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_borrow;

  int n_chk  = 0;
  int n_fail = 0;

  sub_share_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_borrow (rsp_borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after a settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  logic [W-1:0] hold_data;

  initial begin
    req_a = '0;
    req_b = '0;
    do_reset();
    req_valid = 4'b1111;
    rst = 1'b1;
    settle();
    chk("rst_ready_forced", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_borrow", rsp_borrow, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // single request
    set_op(0, 20, 7);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    settle();
    chk("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    settle();
    chk("single_calc_ready", req_ready, 4'b0000);
    chk("single_calc_valid", rsp_valid, 0);
    tick();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_data", rsp_data, 13);
    chk("single_borrow", rsp_borrow, 0);
    tick();
    chk("single_done", rsp_valid, 0);

    // round robin, all four held valid
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i + 10), W'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    begin
      int exp_id [5] = '{0, 1, 2, 3, 0};
      for (int t = 0; t < 5; t++) begin
        settle();
        chk("rr_grant", req_ready, 64'(4'b0001 << exp_id[t]));
        tick();
        chk("rr_calc_ready", req_ready, 0);
        tick();
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, 64'(exp_id[t]));
        chk("rr_data", rsp_data, 10);
        tick();
      end
    end
    req_valid = '0;

    // borrow
    do_reset();
    set_op(0, 3, 5);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    chk("borrow_valid", rsp_valid, 1);
`ifdef SUB_ARB_SAT_EN
    chk("borrow_data", rsp_data, 0);
`else
    chk("borrow_data", rsp_data, 32'hFFFF_FFFE);
`endif
    chk("borrow_flag", rsp_borrow, 1);
    tick();

    // backpressure
    do_reset();
    set_op(0, 50, 8);
    set_op(1, 9, 4);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    settle();
    chk("bp_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1110;
    tick();
    chk("bp_valid_rise", rsp_valid, 1);
    hold_data = rsp_data;
    chk("bp_data", rsp_data, 42);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 42);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_ready_low", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_last_valid", rsp_valid, 1);
    tick();
    chk("bp_released", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    chk("bp_next_id", rsp_id, 1);
    chk("bp_next_data", rsp_data, 5);
    tick();

    // reset mid-operation: first move ptr to 3 by serving requester 2
    do_reset();
    set_op(2, 7, 2);
    set_op(3, 100, 1);
    set_op(0, 8, 8);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    chk("mid_pre_id", rsp_id, 2);
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    rst = 1'b1;
    settle();
    chk("mid_calc_valid", rsp_valid, 0);
    chk("mid_calc_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    req_valid = 4'b1001;
    settle();
    chk("mid_ptr_restart", req_ready, 4'b0001);
    req_valid = 4'b1000;
    settle();
    chk("mid_grant3", req_ready, 4'b1000);
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    chk("mid_resp_valid", rsp_valid, 1);
    chk("mid_resp_id", rsp_id, 3);
    rst = 1'b1;
    settle();
    chk("mid_resp_reset_valid", rsp_valid, 0);
    chk("mid_resp_reset_data", rsp_data, 0);
    tick();
    rst = 1'b0;

    // wrap: ptr=2 after serving 1, then 3 granted, then 0
    do_reset();
    set_op(1, 1, 1);
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b1001;
    settle();
    chk("wrap_grant3", req_ready, 4'b1000);
    tick();
    tick();
    chk("wrap_id3", rsp_id, 3);
    chk("wrap_data3", rsp_data, 99);
    tick();
    settle();
    chk("wrap_grant0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("wrap_id0", rsp_id, 0);
    chk("wrap_data0", rsp_data, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sub_share_arb.md
# sub_share_arb

Round-robin arbiter and sequencer that shares one `sub` subtractor instance among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, drives the shared `sub` with the latched operands, and returns a registered difference tagged with the requester ID. It sits between requesting datapath units and the single `sub` datapath.

## Interface
- `WIDTH`, default 32: operand and result width, passed to the internal `sub` instance.
- `NREQ`, default 4: number of requesters, minimum 2.
- `IDW`, default `$clog2(NREQ)`: requester ID width (localparam).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, `NREQ`: per-requester request valid.
- `req_ready`, out, `NREQ`: per-requester accept; at most one bit set (one-hot).
- `req_a`, in, `NREQ*WIDTH`: minuends; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `req_b`, in, `NREQ*WIDTH`: subtrahends, same packing as `req_a`.
- `rsp_valid`, out, 1: result valid.
- `rsp_ready`, in, 1: result consumer ready.
- `rsp_id`, out, `IDW`: index of the requester that owns the result.
- `rsp_data`, out, `WIDTH`: result, a − b.
- `rsp_borrow`, out, 1: set when a < b (unsigned).

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - Grant the first asserted `req_valid` bit, searching from `ptr` upward modulo `NREQ`.
  - `req_ready[grant]` = 1 combinationally. All other ready bits are 0, and all are 0 if no request is valid.
  - Handshake (`req_valid[i] & req_ready[i]`): latch `req_a[i]` and `req_b[i]` into operand registers `op_a` and `op_b`, latch `i` into `gnt_id`, and go to CALC.
- **CALC**
  - `op_a` and `op_b` drive `sub.in1` and `sub.in2`.
  - Register `sub.out` into `rsp_data`, `(op_a < op_b)` into `rsp_borrow`, and `gnt_id` into `rsp_id`.
  - Set `rsp_valid` and go to RESP.
  - `req_ready` is all 0.
- **RESP**
  - Hold `rsp_*` stable while `rsp_valid & !rsp_ready`.
  - On `rsp_ready`: clear `rsp_valid`, set `ptr` = (`gnt_id` + 1) mod `NREQ`, and go to IDLE.
  - `req_ready` is all 0.
- Arithmetic: unsigned, modulo 2^WIDTH. `rsp_borrow` is independent of the wrap.
- Fairness: after requester i is served, i has the lowest priority for the next grant. Any continuously asserted request is granted within `NREQ` transactions.
- Requests that drop `req_valid` before being granted are not remembered.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `rsp_borrow` = 0.
- While `rst` is high, `req_ready` is forced to 0.
- Latency: with a handshake at cycle T, `rsp_valid` is 1 from cycle T+2.
- Peak throughput: one transaction per 3 cycles when `rsp_ready` is held at 1.
- Reset mid-transaction (in CALC or RESP): the in-flight result is discarded immediately, all outputs return to reset values, and no response is emitted.
- Simultaneous requests are resolved by `ptr` only. Requester index order matters only relative to `ptr`.
- In RESP, `rsp_ready` may already be high in the cycle `rsp_valid` rises; the response then completes in that cycle.
- `ptr` wraps from `NREQ-1` to 0.

## Configuration
- Macro: `SUB_ARB_SAT_EN`.
- **Defined:** saturating subtract. When a < b, `rsp_data` = 0 and `rsp_borrow` = 1.
- **Undefined:** `rsp_data` is the modulo-2^WIDTH difference from `sub`. `rsp_borrow` is still reported.
- The handshake, latency and all other behaviour are identical in both builds.

## Test plan
- **Single request:** after reset, `req_valid` = 4'b0001, a0 = 20, b0 = 7, `rsp_ready` = 1.
  - `req_ready` = 4'b0001 for one cycle.
  - Two cycles later: `rsp_valid` = 1, `rsp_id` = 0, `rsp_data` = 13, `rsp_borrow` = 0.
- **Round robin:** all four requests held valid, with operands i+10 and i (for requester i).
  - Grants occur in order 0, 1, 2, 3, 0.
  - Every `rsp_data` = 10.
  - One response every 3 cycles.
- **Borrow:** a = 3, b = 5, `WIDTH` = 32.
  - Without the macro: `rsp_data` = 32'hFFFF_FFFE, `rsp_borrow` = 1.
  - With `SUB_ARB_SAT_EN`: `rsp_data` = 0, `rsp_borrow` = 1.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles after `rsp_valid` rises.
  - `rsp_*` stay stable.
  - `req_ready` stays 0 despite pending `req_valid` = 4'b1110.
  - After `rsp_ready` rises, the next grant goes to requester 1 when `gnt_id` was 0.
- **Reset mid-operation:** assert `rst` in the CALC cycle.
  - Same cycle: `rsp_valid` = 0 and `req_ready` = 0.
  - After release with `req_valid` = 4'b1000, requester 3 is granted and `ptr` restarts from 0.
- **Wrap:** serve requester 3 with only requests 3 and 0 pending.
  - Next grant is requester 0.
  - `ptr` = 0 after requester 3 is served.
